// File: rtl/sine_pkg.sv
// Shared constants and state/type definitions for the quarter-sine table logic.
// Used by the quarter-sine writer and the address map that the full-sine reader shares.
// Offset-binary samples: midscale 1024, full-scale 2047 at the default width.
package sine_pkg;

   localparam int SINE_DW   = 11;
   localparam int SINE_QAW  = 6;
   localparam int SINE_MID  = 1024;
   localparam int SINE_FULL = 2047;

   // DRAIN holds off DONE until the last sample's compare has been registered.
   typedef enum logic [2:0] {
      QW_IDLE,
      QW_LOAD,
      QW_CHECK,
      QW_DRAIN,
      QW_DONE
   } qw_state_t;

   // What the compare stage does with a sample once the BRAM read returns.
   typedef enum logic [1:0] {
      CK_NONE,    // stored sample, nothing to compare
      CK_MID,     // must equal midscale (indices 0 and 128)
      CK_DIRECT,  // must equal the stored quarter sample
      CK_NEG      // must equal full-scale minus the stored quarter sample
   } qw_chk_t;

endpackage

// File: rtl/quartsine_addr_map.sv
// Maps a full-period sample index to its quarter-memory address and sign/midscale flags.
// Latency: combinational. Backpressure: none (pure function of idx).
// Ports: idx = full-period index; addr = quarter address; neg = lower half-wave; mid = 0 or 128.
module quartsine_addr_map
   import sine_pkg::*;
#(
   parameter int QAW = SINE_QAW
) (
   input  logic [QAW+1:0] idx,
   output logic [QAW-1:0] addr,
   output logic           neg,
   output logic           mid
);

   // Rising quadrants (0, 2) walk the table forward offset by one because the
   // zero-crossing sample is not stored; falling quadrants (1, 3) mirror it.
   // Index 64 and 192 both land on address 63 through either form.
   always_comb begin
      addr = idx[QAW] ? ~idx[QAW-1:0] : (idx[QAW-1:0] - QAW'(1));
      neg  = idx[QAW+1];
      mid  = ~idx[QAW] && (idx[QAW-1:0] == '0);
   end

endmodule

// File: rtl/quartsine_writer.sv
// Loads the quarter-sine BRAM from a streamed full-period table and checks the other quadrants.
// Latency: BRAM write 2 edges after handshake; error flags and done 3 cycles after handshake.
// Backpressure: s_ready high throughout LOAD/CHECK, never dropped mid-run; s_valid gaps stall.
// Ports: start/s_* = sample stream in; ena/wea/addra/dina/douta = BRAM port A;
//        busy/done/sym_err/len_err/err_cnt = status.
module quartsine_writer
   import sine_pkg::*;
#(
   parameter int DW  = SINE_DW,
   parameter int QAW = SINE_QAW
) (
   input  logic           clka,
   input  logic           rstn,
   input  logic           start,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [DW-1:0]  s_data,
   input  logic           s_last,
   output logic           ena,
   output logic           wea,
   output logic [QAW-1:0] addra,
   output logic [DW-1:0]  dina,
   input  logic [DW-1:0]  douta,
   output logic           busy,
   output logic           done,
   output logic           sym_err,
   output logic           len_err,
   output logic [7:0]     err_cnt
);

   localparam int            IW       = QAW + 2;
   localparam logic [DW-1:0] MID_VAL  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] FULL_VAL = {DW{1'b1}};
   localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};
   localparam logic [IW-1:0] QEND_IDX = {2'b01, {QAW{1'b0}}};

   qw_state_t      state, state_nxt;
   logic [IW-1:0]  idx;
   logic           hs;
   logic [QAW-1:0] map_addr;
   logic           map_neg;
   logic           map_mid;

   // Compare pipeline: stage 1 waits for the BRAM read, stage 2 sees douta.
   logic           s1_vld;
   qw_chk_t        s1_kind;
   logic [DW-1:0]  s1_data;
   logic           s2_vld;
   qw_chk_t        s2_kind;
   logic [DW-1:0]  s2_data;
   logic           mismatch;

   assign hs = s_valid && s_ready;

   quartsine_addr_map #(.QAW(QAW)) u_map (
      .idx  (idx),
      .addr (map_addr),
      .neg  (map_neg),
      .mid  (map_mid)
   );

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) state <= QW_IDLE;
      else       state <= state_nxt;
   end

   // s_valid is used directly here (s_ready is 1 in LOAD/CHECK) to keep
   // s_ready out of its own fan-in.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         QW_IDLE: begin
            if (start) state_nxt = QW_LOAD;
         end
         QW_LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               if (s_last)               state_nxt = QW_DRAIN;
               else if (idx == QEND_IDX) state_nxt = QW_CHECK;
            end
         end
         QW_CHECK: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid && (s_last || idx == LAST_IDX)) state_nxt = QW_DRAIN;
         end
         QW_DRAIN: begin
            busy = 1'b1;
            // Once stage 1 is empty the last compare lands on the next edge.
            if (!s1_vld) state_nxt = QW_DONE;
         end
         QW_DONE: begin
            done      = 1'b1;
            state_nxt = QW_IDLE;
         end
         default: state_nxt = QW_IDLE;
      endcase
   end

   always_comb begin
      mismatch = 1'b0;
      case (s2_kind)
         CK_MID:    mismatch = (s2_data != MID_VAL);
         CK_DIRECT: mismatch = (s2_data != douta);
         CK_NEG:    mismatch = (s2_data != (FULL_VAL - douta));
         default:   mismatch = 1'b0;
      endcase
   end

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         idx     <= '0;
         ena     <= 1'b0;
         wea     <= 1'b0;
         addra   <= '0;
         dina    <= '0;
         s1_vld  <= 1'b0;
         s1_kind <= CK_NONE;
         s1_data <= '0;
         s2_vld  <= 1'b0;
         s2_kind <= CK_NONE;
         s2_data <= '0;
         sym_err <= 1'b0;
         len_err <= 1'b0;
         err_cnt <= '0;
      end else begin
         ena     <= 1'b0;
         wea     <= 1'b0;
         s1_vld  <= hs;
         s2_vld  <= s1_vld;
         s2_kind <= s1_kind;
         s2_data <= s1_data;

         if (state == QW_IDLE && start) begin
            idx     <= '0;
            sym_err <= 1'b0;
            len_err <= 1'b0;
            err_cnt <= '0;
         end

         if (hs) begin
            idx     <= idx + IW'(1);
            s1_data <= s_data;
            if (map_mid) begin
               s1_kind <= CK_MID;
            end else begin
               ena   <= 1'b1;
               addra <= map_addr;
               if (state == QW_LOAD) begin
                  wea     <= 1'b1;
                  dina    <= s_data;
                  s1_kind <= CK_NONE;
               end else begin
                  s1_kind <= map_neg ? CK_NEG : CK_DIRECT;
               end
            end
            // s_last must coincide exactly with the final index.
            if (s_last != (idx == LAST_IDX)) len_err <= 1'b1;
         end

         if (s2_vld && mismatch) begin
            sym_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_quartsine_writer.sv
module tb_quartsine_writer;
   import sine_pkg::*;

   localparam int DW  = SINE_DW;
   localparam int QAW = SINE_QAW;

   logic           clka = 1'b0;
   logic           rstn;
   logic           start;
   logic           s_valid;
   logic           s_ready;
   logic [DW-1:0]  s_data;
   logic           s_last;
   logic           ena;
   logic           wea;
   logic [QAW-1:0] addra;
   logic [DW-1:0]  dina;
   logic [DW-1:0]  douta;
   logic           busy;
   logic           done;
   logic           sym_err;
   logic           len_err;
   logic [7:0]     err_cnt;

   quartsine_writer dut (
      .clka    (clka),
      .rstn    (rstn),
      .start   (start),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .ena     (ena),
      .wea     (wea),
      .addra   (addra),
      .dina    (dina),
      .douta   (douta),
      .busy    (busy),
      .done    (done),
      .sym_err (sym_err),
      .len_err (len_err),
      .err_cnt (err_cnt)
   );

   always #5 clka = ~clka;

   int cyc = 0;
   always @(posedge clka) cyc <= cyc + 1;

   // Behavioural BRAM, 1-cycle read latency, read-before-write.
   logic [DW-1:0] bram [64];
   always @(posedge clka) begin
      if (ena) begin
         if (wea) bram[addra] <= dina;
         douta <= bram[addra];
      end
   end

   int   tbl     [256];
   int   ref_mem [64];
   int   hs_cyc  [256];
   int   hs_n;
   int   done_cyc;
   int   done_busy;
   int   err_cyc;
   logic hs;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: sample everything at the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clka);
      hs = s_valid && s_ready;
      if (hs && hs_n < 256) begin
         hs_cyc[hs_n] = cyc;
         hs_n++;
      end
      if (done && done_cyc < 0) begin
         done_cyc  = cyc;
         done_busy = int'(busy);
      end
      if (err_cnt != 8'd0 && err_cyc < 0) err_cyc = cyc;
      @(posedge clka);
      #1;
   endtask

   task automatic build_ideal();
      for (int i = 0; i < 256; i++) begin
         tbl[i] = int'(1023.5 + 1023.5 * $sin(2.0 * 3.14159265358979 * i / 256.0));
         if (i == 0 || i == 128) tbl[i] = 1024;
      end
   endtask

   // Streams samples 0..stop_idx; s_last asserted on last_idx (-1 = never).
   task automatic run(input int stop_idx, input int last_idx, input int gap_pct);
      int idx;
      int guard;
      hs_n     = 0;
      done_cyc = -1;
      done_busy = -1;
      err_cyc  = -1;
      for (int k = 0; k < 256; k++) hs_cyc[k] = -1000;
      start = 1'b1;
      tick();
      start = 1'b0;
      idx   = 0;
      guard = 0;
      while (idx <= stop_idx && guard < 5000) begin
         s_valid = ($urandom_range(99) >= gap_pct);
         s_data  = DW'(tbl[idx]);
         s_last  = (idx == last_idx);
         tick();
         if (hs) idx++;
         guard++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic finish_run(input string tag, input int last_i);
      int guard;
      guard = 0;
      while (done_cyc < 0 && guard < 40) begin
         tick();
         guard++;
      end
      chk($sformatf("%s_done_lat", tag), done_cyc - hs_cyc[last_i], 3);
      chk($sformatf("%s_busy_at_done", tag), done_busy, 0);
      @(negedge clka);
      chk($sformatf("%s_done_pulse", tag), int'(done), 0);
      chk($sformatf("%s_idle_ready", tag), int'(s_ready), 0);
      @(posedge clka);
      #1;
   endtask

   // Reference: samples 1..64 are the stored quarter; every later sample must match
   // the quarter-wave mirror image (negated about full-scale on the lower half-wave);
   // samples 0 and 128 must sit at midscale.
   task automatic check_results(input string tag, input int stop_idx, input int last_idx,
                                input bit chk_mem);
      int cnt;
      int expv;
      cnt = 0;
      for (int i = 0; i <= stop_idx; i++) begin
         if (i >= 1 && i <= 64) begin
            ref_mem[i-1] = tbl[i];
         end else begin
            if (i == 0 || i == 128) expv = SINE_MID;
            else if (i < 128)       expv = tbl[128 - i];
            else if (i < 192)       expv = SINE_FULL - tbl[i - 128];
            else                    expv = SINE_FULL - tbl[256 - i];
            if (tbl[i] != expv) cnt++;
         end
      end
      if (cnt > 255) cnt = 255;
      chk($sformatf("%s_err_cnt", tag), int'(err_cnt), cnt);
      chk($sformatf("%s_sym_err", tag), int'(sym_err), (cnt != 0) ? 1 : 0);
      chk($sformatf("%s_len_err", tag), int'(len_err), (last_idx != 255) ? 1 : 0);
      if (chk_mem) begin
         for (int a = 0; a < 64; a++)
            chk($sformatf("%s_bram%0d", tag, a), int'(bram[a]), ref_mem[a]);
      end
   endtask

   task automatic check_reset(input string tag);
      chk($sformatf("%s_s_ready", tag), int'(s_ready), 0);
      chk($sformatf("%s_ena", tag),     int'(ena),     0);
      chk($sformatf("%s_wea", tag),     int'(wea),     0);
      chk($sformatf("%s_addra", tag),   int'(addra),   0);
      chk($sformatf("%s_dina", tag),    int'(dina),    0);
      chk($sformatf("%s_busy", tag),    int'(busy),    0);
      chk($sformatf("%s_done", tag),    int'(done),    0);
      chk($sformatf("%s_sym_err", tag), int'(sym_err), 0);
      chk($sformatf("%s_len_err", tag), int'(len_err), 0);
      chk($sformatf("%s_err_cnt", tag), int'(err_cnt), 0);
   endtask

   initial begin
      int p;
      rstn    = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      hs_n    = 0;
      repeat (3) @(posedge clka);
      @(negedge clka);
      check_reset("reset");
      @(posedge clka);
      #1 rstn = 1'b1;
      tick();

      // Ideal table at full rate.
      build_ideal();
      run(255, 255, 0);
      finish_run("ideal", 255);
      check_results("ideal", 255, 255, 1'b1);
      chk("ideal_no_err_seen", err_cyc, -1);

      // Single corrupted sample in the lower half-wave.
      tbl[200] = tbl[200] + 1;
      run(255, 255, 0);
      finish_run("corrupt", 255);
      check_results("corrupt", 255, 255, 1'b0);
      chk("corrupt_err_lat", err_cyc - hs_cyc[200], 3);

      // Early s_last at 100.
      build_ideal();
      run(100, 100, 0);
      finish_run("early", 100);
      check_results("early", 100, 100, 1'b1);

      // Random stalls on s_valid.
      run(255, 255, 30);
      finish_run("gaps", 255);
      check_results("gaps", 255, 255, 1'b1);

      // Reset in the middle of the load, then a clean rerun.
      run(40, -1, 0);
      tick();
      tick();
      rstn = 1'b0;
      @(negedge clka);
      check_reset("midrst");
      @(posedge clka);
      #1 rstn = 1'b1;
      tick();
      run(255, 255, 0);
      finish_run("rerun", 255);
      check_results("rerun", 255, 255, 1'b1);

      // All-zero table: every midscale and lower-half sample mismatches.
      for (int i = 0; i < 256; i++) tbl[i] = 0;
      run(255, 255, 0);
      finish_run("zeros", 255);
      check_results("zeros", 255, 255, 1'b1);

      // Random perturbations and s_last never asserted.
      build_ideal();
      for (int k = 0; k < 6; k++) begin
         p = $urandom_range(255);
         tbl[p] = (tbl[p] + $urandom_range(1, 3)) % 2048;
      end
      run(255, -1, 10);
      finish_run("rand", 255);
      check_results("rand", 255, -1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
